// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types plus default configuration for the RAM responder.
package cpu_types_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned RAM_LAT     = 2;
  localparam int unsigned RAM_DEPTH_W = 8;
  localparam int unsigned RAM_CNT_W   = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } ramreq_t;

endpackage

// File: rtl/ram_array.sv
// Word-wide backing store: one synchronous write port, one registered read port.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH_W = RAM_DEPTH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  word_t              wdata_i,
  input  logic               re_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output word_t              rdata_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Latency-configurable RAM responder: FREE/BUSY/ACCESS/ERROR handshake FSM
// in front of a ram_array.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT     = RAM_LAT,
  parameter int unsigned DEPTH_W = RAM_DEPTH_W
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam logic [RAM_CNT_W-1:0] CNT_INIT =
    (LAT == 0) ? '0 : RAM_CNT_W'(LAT - 1);

  ramstate_t            state_q, state_d;
  logic [RAM_CNT_W-1:0] cnt_q, cnt_d;
  ramreq_t              req_q, req_d;
  logic [DEPTH_W-1:0]   idx_q, idx_d;
  word_t                data_q, data_d;

  logic                 req_any_c;
  logic                 req_ok_c;
  logic [DEPTH_W-1:0]   in_idx_c;
  logic                 mem_we_c;
  logic                 mem_re_c;
  logic [DEPTH_W-1:0]   mem_idx_c;
  word_t                mem_wdata_c;
  logic                 unused_addr_c;

  assign req_any_c     = ramREN | ramWEN;
  assign req_ok_c      = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00);
  assign in_idx_c      = ramaddr[DEPTH_W+1:2];
  assign unused_addr_c = ^ramaddr[WORD_W-1:DEPTH_W+2];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      req_q   <= REQ_NONE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next-state and memory-port control; the array is accessed on the edge
  // that enters ACCESS so ramload is valid for the whole ACCESS cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    idx_d       = idx_q;
    data_d      = data_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_idx_c   = idx_q;
    mem_wdata_c = data_q;

    unique case (state_q)
      FREE: begin
        if (req_any_c) begin
          if (req_ok_c) begin
            req_d  = ramWEN ? REQ_WRITE : REQ_READ;
            idx_d  = in_idx_c;
            data_d = ramstore;
            if (LAT == 0) begin
              state_d     = ACCESS;
              cnt_d       = '0;
              mem_idx_c   = in_idx_c;
              mem_wdata_c = ramstore;
              mem_we_c    = ramWEN;
              mem_re_c    = ramREN;
            end else begin
              state_d = BUSY;
              cnt_d   = CNT_INIT;
            end
          end else begin
            state_d = ERROR;
          end
        end
      end
      BUSY: begin
        if (!req_any_c) begin
          state_d = FREE;
          req_d   = REQ_NONE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = ACCESS;
          mem_we_c = (req_q == REQ_WRITE);
          mem_re_c = (req_q == REQ_READ);
        end else begin
          cnt_d = cnt_q - RAM_CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d = FREE;
        req_d   = REQ_NONE;
      end
      ERROR: begin
        state_d = FREE;
      end
      default: begin
        state_d = FREE;
      end
    endcase
  end

  ram_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk     (CLK),
    .rst_n   (nRST),
    .we_i    (mem_we_c & nRST),
    .waddr_i (mem_idx_c),
    .wdata_i (mem_wdata_c),
    .re_i    (mem_re_c),
    .raddr_i (mem_idx_c),
    .rdata_o (ramload)
  );

  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: instance 0 runs LAT=2, instance 1 LAT=0.
module tb_ram_responder;
  import cpu_types_pkg::*;

  typedef struct {
    ramstate_t st;
    word_t     ld;
    int        tag;
  } exp_t;

  logic      clk = 1'b0;
  logic [1:0] nrst = 2'b00;
  logic [1:0] ren  = 2'b00;
  logic [1:0] wen  = 2'b00;
  word_t     addr  [2];
  word_t     store [2];
  word_t     load  [2];
  ramstate_t st    [2];
  word_t     eld   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .DEPTH_W(8)) dut0 (
    .CLK(clk), .nRST(nrst[0]), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]), .ramload(load[0]), .ramstate(st[0])
  );

  ram_responder #(.LAT(0), .DEPTH_W(8)) dut1 (
    .CLK(clk), .nRST(nrst[1]), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]), .ramload(load[1]), .ramstate(st[1])
  );

  // Drive one cycle on instance s and queue what must be seen after the edge.
  task automatic cyc(input int s, input bit r, input bit w, input word_t a,
                     input word_t d, input bit rn, input ramstate_t es, input int tg);
    exp_t e;
    @(negedge clk);
    ren[s]   = r;
    wen[s]   = w;
    addr[s]  = a;
    store[s] = d;
    nrst[s]  = rn;
    e.st  = es;
    e.ld  = eld[s];
    e.tag = tg;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic idle(input int s, input int tg);
    cyc(s, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, FREE, tg);
  endtask

  // Full transaction: lat BUSY cycles, ACCESS, then FREE. Address and data are
  // perturbed during BUSY; the latched values must win.
  task automatic txn(input int s, input int lat, input bit r, input bit w,
                     input word_t a, input word_t d, input word_t rdval, input int tg);
    for (int i = 0; i <= lat; i++) begin
      if (i == lat && r) eld[s] = rdval;
      cyc(s, r, w, (i == 0) ? a : (a ^ 32'h44), (i == 0) ? d : ~d, 1'b1,
          (i < lat) ? BUSY : ACCESS, tg);
    end
    idle(s, tg);
  endtask

  // Monitor: compare each queued expectation shortly after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if (st[0] !== e.st || load[0] !== e.ld) begin
        errors++;
        $display("FAIL tag%0d lat2: state=%0d load=%h, expected state=%0d load=%h",
                 e.tag, int'(st[0]), load[0], int'(e.st), e.ld);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if (st[1] !== e.st || load[1] !== e.ld) begin
        errors++;
        $display("FAIL tag%0d lat0: state=%0d load=%h, expected state=%0d load=%h",
                 e.tag, int'(st[1]), load[1], int'(e.st), e.ld);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      store[i] = '0;
      eld[i]   = '0;
    end

    // Reset both instances.
    for (int i = 0; i < 2; i++) cyc(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, FREE, 1);
    idle(0, 1);
    for (int i = 0; i < 2; i++) cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, FREE, 2);
    idle(1, 2);

    // LAT=2 basic write then read.
    txn(0, 2, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 10);
    txn(0, 2, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 11);

    // Illegal requests give one ERROR cycle and leave memory alone.
    txn(0, 2, 1'b0, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 32'h0, 20);
    cyc(0, 1'b1, 1'b1, 32'h0000_0008, 32'h5555_5555, 1'b1, ERROR, 21);
    idle(0, 21);
    cyc(0, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 1'b1, ERROR, 22);
    idle(0, 22);
    txn(0, 2, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 23);

    // Abort by dropping WEN in the second BUSY cycle.
    txn(0, 2, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 30);
    cyc(0, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, BUSY, 31);
    cyc(0, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, BUSY, 31);
    idle(0, 31);
    txn(0, 2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 32);

    // Address aliasing above the array depth.
    txn(0, 2, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0001, 32'h0, 40);
    txn(0, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0001, 41);

    // Reset mid-BUSY discards the write and clears ramload.
    txn(0, 2, 1'b0, 1'b1, 32'h0000_0030, 32'h2222_2222, 32'h0, 50);
    cyc(0, 1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_0000, 1'b1, BUSY, 51);
    eld[0] = 32'h0;
    cyc(0, 1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_0000, 1'b0, FREE, 51);
    idle(0, 51);
    txn(0, 2, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h2222_2222, 52);

    // LAT=0: no BUSY cycle; a request held into FREE starts a new access.
    txn(1, 0, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0, 60);
    txn(1, 0, 1'b0, 1'b1, 32'h0000_0008, 32'h9ABC_DEF0, 32'h0, 61);
    eld[1] = 32'h1234_5678;
    cyc(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, ACCESS, 62);
    cyc(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, FREE, 62);
    eld[1] = 32'h9ABC_DEF0;
    cyc(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, ACCESS, 62);
    idle(1, 62);
    cyc(1, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 1'b1, ERROR, 63);
    idle(1, 63);
    txn(1, 0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 64);

    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d/%0d, expected 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
